nand_share_arb: RTL and testbench



---
 rtl/nand_share_arb.sv | 141 ++++++++++++++
 tb/tb_nand_share_arb.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/nand_share_arb.sv
// nand_share_arb
//   Shares one W-bit bitwise NAND unit among N requesters using round-robin
//   arbitration. A granted requester's operands are latched. One cycle later
//   the block returns z = ~(x & y) with a one-cycle valid pulse addressed to
//   that requester.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req        [N]    per-requester request level
//   x_flat     [N*W]  operand x, requester i at [i*W +: W]
//   y_flat     [N*W]  operand y, requester i at [i*W +: W]
//   gnt        [N]    one-hot grant pulse (the cycle the op is in EVAL)
//   rsp_valid  [N]    one-hot result-valid pulse, one cycle after gnt
//   rsp_data   [W]    last completed result, held between ops
//   busy       high while in EVAL; this is the FSM state bit itself
//   done_cnt   [16]   completed-transaction counter, wraps
//
// Handshake: a requester holds req and its operands until it sees gnt high.
// It may drop req during the gnt cycle. If req is still high in the next
// IDLE cycle, that is a new request. req is not looked at while in EVAL.
module nand_share_arb #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] x_flat,
  input  logic [N*W-1:0] y_flat,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           busy,
  output logic [15:0]    done_cnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [W-1:0]    op_x_q, op_x_d;
  logic [W-1:0]    op_y_q, op_y_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [15:0]     done_cnt_q, done_cnt_d;

  // Round-robin search: the first set request scanning from ptr upward
  // modulo N. N need not be a power of two, so the wrap is done explicitly.
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  int              scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    scan_idx  = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      cand = PW'(scan_idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    done_cnt_d  = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          op_x_d         = x_flat[win_idx*W +: W];
          op_y_d         = y_flat[win_idx*W +: W];
          owner_d        = win_idx;
          gnt_d[win_idx] = 1'b1;
          state_d        = EVAL;
        end
      end
      EVAL: begin
        rsp_data_d           = ~(op_x_q & op_y_q);
        rsp_valid_d[owner_q] = 1'b1;
        // The search restarts just past the requester that was served.
        // This is what bounds a continuous requester to one service per N ops.
        ptr_d      = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
        done_cnt_d = done_cnt_q + 16'd1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q == EVAL);
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_nand_share_arb.sv
// tb_nand_share_arb
//   Bench for nand_share_arb with N=4 and W=8. Inputs change on the falling
//   edge, and outputs are sampled on the falling edge that follows.
module tb_nand_share_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] x_flat;
  logic [N*W-1:0] y_flat;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic [15:0]    done_cnt;

  int checks   = 0;
  int failures = 0;

  nand_share_arb #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .x_flat    (x_flat),
    .y_flat    (y_flat),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] xf;
    logic [31:0] yf;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [7:0]  data;
    logic        busy;
    logic [15:0] done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] r, input logic [31:0] xf,
                              input logic [31:0] yf, input logic [3:0] g,
                              input logic [3:0] rv, input logic [7:0] d,
                              input logic b, input logic [15:0] dc);
    vec_t v;
    v.req = r; v.xf = xf; v.yf = yf; v.gnt = g; v.rv = rv;
    v.data = d; v.busy = b; v.done = dc;
    vecs.push_back(v);
  endfunction

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] rv,
                         input logic [7:0] d, input logic b, input logic [15:0] dc);
    chk({tag, " gnt"},       32'(gnt),       32'(g));
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(rv));
    chk({tag, " rsp_data"},  32'(rsp_data),  32'(d));
    chk({tag, " busy"},      32'(busy),      32'(b));
    chk({tag, " done_cnt"},  32'(done_cnt),  32'(dc));
  endtask

  // driver: apply inputs, let one rising edge pass, and sample on the falling edge
  task automatic drive(input logic [3:0] r, input logic [31:0] xf, input logic [31:0] yf);
    req = r; x_flat = xf; y_flat = yf;
    @(negedge clk);
  endtask

  localparam logic [31:0] CX = 32'h84422110; // results with y=FF: EF DE BD 7B
  localparam logic [31:0] CY = 32'hFFFFFFFF;

  initial begin
    rst_n = 1'b0; req = '0; x_flat = '0; y_flat = '0;

    // single request 0: 0xF0 NAND 0x3C = 0xCF
    add(4'b0001, 32'h000000F0, 32'h0000003C, 4'b0001, 4'b0000, 8'h00, 1'b1, 16'd0);
    add(4'b0000, 32'h000000F0, 32'h0000003C, 4'b0000, 4'b0001, 8'hCF, 1'b0, 16'd1);
    // truth table on requester 2
    add(4'b0100, 32'h00000000, 32'h00000000, 4'b0100, 4'b0000, 8'hCF, 1'b1, 16'd1);
    add(4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 4'b0100, 8'hFF, 1'b0, 16'd2);
    add(4'b0100, 32'h00FF0000, 32'h00000000, 4'b0100, 4'b0000, 8'hFF, 1'b1, 16'd2);
    add(4'b0000, 32'h00FF0000, 32'h00000000, 4'b0000, 4'b0100, 8'hFF, 1'b0, 16'd3);
    add(4'b0100, 32'h00000000, 32'h00FF0000, 4'b0100, 4'b0000, 8'hFF, 1'b1, 16'd3);
    add(4'b0000, 32'h00000000, 32'h00FF0000, 4'b0000, 4'b0100, 8'hFF, 1'b0, 16'd4);
    add(4'b0100, 32'h00FF0000, 32'h00FF0000, 4'b0100, 4'b0000, 8'hFF, 1'b1, 16'd4);
    add(4'b0000, 32'h00FF0000, 32'h00FF0000, 4'b0000, 4'b0100, 8'h00, 1'b0, 16'd5);
    add(4'b0000, 32'h00FF0000, 32'h00FF0000, 4'b0000, 4'b0000, 8'h00, 1'b0, 16'd5);
    // contention: ptr=3 after serving 2, so the order is 3,0,1,2,3
    add(4'b1111, CX, CY, 4'b1000, 4'b0000, 8'h00, 1'b1, 16'd5);
    add(4'b1111, CX, CY, 4'b0000, 4'b1000, 8'h7B, 1'b0, 16'd6);
    add(4'b1111, CX, CY, 4'b0001, 4'b0000, 8'h7B, 1'b1, 16'd6);
    add(4'b1111, CX, CY, 4'b0000, 4'b0001, 8'hEF, 1'b0, 16'd7);
    add(4'b1111, CX, CY, 4'b0010, 4'b0000, 8'hEF, 1'b1, 16'd7);
    add(4'b1111, CX, CY, 4'b0000, 4'b0010, 8'hDE, 1'b0, 16'd8);
    add(4'b1111, CX, CY, 4'b0100, 4'b0000, 8'hDE, 1'b1, 16'd8);
    add(4'b1111, CX, CY, 4'b0000, 4'b0100, 8'hBD, 1'b0, 16'd9);
    add(4'b1111, CX, CY, 4'b1000, 4'b0000, 8'hBD, 1'b1, 16'd9);
    // pointer wrap: req changes to 1001 while in EVAL (ignored there)
    add(4'b1001, CX, CY, 4'b0000, 4'b1000, 8'h7B, 1'b0, 16'd10);
    add(4'b1001, CX, CY, 4'b0001, 4'b0000, 8'h7B, 1'b1, 16'd10);
    add(4'b1001, CX, CY, 4'b0000, 4'b0001, 8'hEF, 1'b0, 16'd11);
    add(4'b1001, CX, CY, 4'b1000, 4'b0000, 8'hEF, 1'b1, 16'd11);
    add(4'b0000, CX, CY, 4'b0000, 4'b1000, 8'h7B, 1'b0, 16'd12);
    add(4'b0000, CX, CY, 4'b0000, 4'b0000, 8'h7B, 1'b0, 16'd12);

    repeat (3) @(negedge clk);
    chk_all("reset", 4'b0000, 4'b0000, 8'h00, 1'b0, 16'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].xf, vecs[i].yf);
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].rv, vecs[i].data,
              vecs[i].busy, vecs[i].done);
    end

    // operand latching: x0 is cleared after the grant, and the result still uses 0xF0
    drive(4'b0001, 32'h000000F0, 32'h0000003C);
    chk_all("latch_gnt", 4'b0001, 4'b0000, 8'h7B, 1'b1, 16'd12);
    drive(4'b0000, 32'h00000000, 32'h0000003C);
    chk_all("latch_rsp", 4'b0000, 4'b0001, 8'hCF, 1'b0, 16'd13);

    // serve requester 1 so that ptr=2, then start requester 3 and reset in EVAL
    drive(4'b0010, 32'h0000AA00, 32'h00000F00);
    chk_all("pre_gnt", 4'b0010, 4'b0000, 8'hCF, 1'b1, 16'd13);
    drive(4'b0000, 32'h0000AA00, 32'h00000F00);
    chk_all("pre_rsp", 4'b0000, 4'b0010, 8'hF5, 1'b0, 16'd14);
    drive(4'b1000, 32'h0000AA00, 32'h00000F00);
    chk_all("mid_gnt", 4'b1000, 4'b0000, 8'hF5, 1'b1, 16'd14);
    rst_n = 1'b0;
    drive(4'b0000, 32'h0000AA00, 32'h00000F00);
    chk_all("mid_rst", 4'b0000, 4'b0000, 8'h00, 1'b0, 16'd0);
    rst_n = 1'b1;
    // with ptr back at 0, req 1010 must pick 1; a stale ptr of 2 would pick 3
    drive(4'b1010, 32'h0000AA00, 32'h00000F00);
    chk_all("post_rst_gnt", 4'b0010, 4'b0000, 8'h00, 1'b1, 16'd0);
    drive(4'b0000, 32'h0000AA00, 32'h00000F00);
    chk_all("post_rst_rsp", 4'b0000, 4'b0010, 8'hF5, 1'b0, 16'd1);

    // counter wrap: preload 0xFFFF, then one op must take it to 0
    force dut.done_cnt_q = 16'hFFFF;
    #1 release dut.done_cnt_q;
    @(negedge clk);
    chk("wrap_preload done_cnt", 32'(done_cnt), 32'h0000FFFF);
    drive(4'b0001, 32'h000000F0, 32'h0000003C);
    chk_all("wrap_gnt", 4'b0001, 4'b0000, 8'hF5, 1'b1, 16'hFFFF);
    drive(4'b0000, 32'h000000F0, 32'h0000003C);
    chk_all("wrap_rsp", 4'b0000, 4'b0001, 8'hCF, 1'b0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
